// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared sequencer state encoding, default latencies and layer-size field extraction
package nn_ctrl_pkg;
  localparam int DEF_MAX_LAYERS = 8;
  localparam int DEF_NW = 6;
  localparam int DEF_MAC_LAT = 10;
  localparam int DEF_AF_LAT = 32;
  // Size-field vectors are zero-extended to this width so that indexing one
  // field past the last layer reads back as 0 instead of going out of range.
  localparam int FIELD_VEC_W = 1024;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, ACT, WRITE, NEXT, DONE} seq_state_e;
  // Returns field k (nw bits wide) of a packed layer-size vector.
  function automatic logic [31:0] field_sz(input logic [FIELD_VEC_W-1:0] vec, input int k, input int nw);
    logic [FIELD_VEC_W-1:0] s;
    s = vec >> (k * nw);
    return s[31:0] & ((32'd1 << nw) - 32'd1);
  endfunction
endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down counter used as the sequencer phase timer
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over counting)
//   en         : count enable; held low while the sequence is stalled
//   load_val   : value loaded; the phase lasts load_val+1 enabled cycles
//   tc         : terminal count, high while the count is 0
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  assign tc = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && !tc) cnt <= cnt - 1'b1;
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: control FSM stepping a CORDIC MAC/activation datapath through a multi-layer network
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : begin a run / return to IDLE (abort wins over stall and start)
//   stall             : freezes the sequence and masks every strobe except busy
//   no_layers         : compute-layer count, captured at start
//   layer_sz          : packed layer sizes, field 0 is the input count, captured at start
//   weight_en..bias_sel : datapath strobes
//   busy, done, cfg_err : run status; done and cfg_err are single-cycle pulses
//   layer_idx, step_idx : current layer and fan-in step
module nn_layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int MAX_LAYERS = DEF_MAX_LAYERS,
  parameter int NW = DEF_NW,
  parameter int MAC_LAT = DEF_MAC_LAT,
  parameter int AF_LAT = DEF_AF_LAT,
  localparam int LW = $clog2(MAX_LAYERS + 1),
  localparam int SZW = (MAX_LAYERS + 1) * NW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           stall,
  input  logic [LW-1:0]  no_layers,
  input  logic [SZW-1:0] layer_sz,
  output logic           weight_en,
  output logic           bias_en,
  output logic           compute_en,
  output logic           af_en,
  output logic           out_shft_en,
  output logic           out_wr_en,
  output logic           out_sel,
  output logic           bias_sel,
  output logic           busy,
  output logic           done,
  output logic           cfg_err,
  output logic [LW-1:0]  layer_idx,
  output logic [NW-1:0]  step_idx
);
  // The phase timer must hold FO (up to 2^NW-1) as well as MAC_LAT-1 and AF_LAT-1.
  localparam int CMAX = ((1 << NW) > MAC_LAT) ? (((1 << NW) > AF_LAT) ? (1 << NW) : AF_LAT)
                                              : ((MAC_LAT > AF_LAT) ? MAC_LAT : AF_LAT);
  localparam int CW = $clog2(CMAX + 1);
  seq_state_e state, nxt_state;
  logic [LW-1:0] nl_q, nxt_layer;
  logic [SZW-1:0] sz_q;
  logic [NW-1:0] nxt_step, fi, fo, fo_nxt, in_fo;
  logic we_q, ce_q, af_q, shft_q, wr_q, osel_q, bsel_q, busy_q, done_q, err_q;
  logic nxt_shft, nxt_err, cap, ld, tc, last, cfg_ok;
  logic [CW-1:0] ld_val;
  assign fi = NW'(field_sz(FIELD_VEC_W'(sz_q), 32'(layer_idx), NW));
  assign fo = NW'(field_sz(FIELD_VEC_W'(sz_q), 32'(layer_idx) + 32'd1, NW));
  assign fo_nxt = NW'(field_sz(FIELD_VEC_W'(sz_q), 32'(layer_idx) + 32'd2, NW));
  assign in_fo = NW'(field_sz(FIELD_VEC_W'(layer_sz), 1, NW));
  assign last = step_idx == fi - 1'b1;
  // Legal config: 1..MAX_LAYERS layers and every size field up to no_layers non-zero.
  always_comb begin
    cfg_ok = (no_layers != '0) && (no_layers <= LW'(MAX_LAYERS));
    for (int k = 0; k <= MAX_LAYERS; k++)
      if (32'(k) <= 32'(no_layers) && field_sz(FIELD_VEC_W'(layer_sz), k, NW) == 32'd0) cfg_ok = 1'b0;
  end
  // The phase timer is reloaded on the same edge that enters each timed phase.
  always_comb begin
    nxt_state = state;
    nxt_layer = layer_idx;
    nxt_step = step_idx;
    nxt_shft = 1'b0;
    nxt_err = 1'b0;
    cap = 1'b0;
    ld = 1'b0;
    ld_val = '0;
    if (abort) begin
      nxt_state = IDLE;
      nxt_layer = '0;
      nxt_step = '0;
    end else if (!stall) begin
      case (state)
        IDLE: if (start) begin
          nxt_err = !cfg_ok;
          cap = cfg_ok;
          ld = cfg_ok;
          ld_val = CW'(in_fo);
          nxt_state = cfg_ok ? LOAD : IDLE;
          nxt_layer = '0;
          nxt_step = '0;
        end
        LOAD: if (tc) begin
          nxt_state = MAC;
          ld = 1'b1;
          ld_val = CW'(MAC_LAT - 1);
        end
        MAC: if (tc) begin
          ld = 1'b1;
          nxt_state = last ? ACT : LOAD;
          nxt_step = last ? step_idx : step_idx + 1'b1;
          nxt_shft = !last && layer_idx != '0;
          ld_val = last ? CW'(AF_LAT - 1) : CW'(fo);
        end
        ACT: if (tc) nxt_state = WRITE;
        WRITE: nxt_state = NEXT;
        NEXT: begin
          nxt_layer = layer_idx + 1'b1;
          nxt_step = '0;
          nxt_state = (nxt_layer == nl_q) ? DONE : LOAD;
          ld = nxt_layer != nl_q;
          ld_val = CW'(fo_nxt);
        end
        DONE: begin
          nxt_state = IDLE;
          nxt_layer = '0;
          nxt_step = '0;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end
  // Strobes are registered from the next state so they line up with it; a stall
  // holds every register, including the single-cycle pulses, until release.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      layer_idx <= '0;
      step_idx <= '0;
      nl_q <= '0;
      sz_q <= '0;
      {we_q, ce_q, af_q, shft_q, wr_q, osel_q, bsel_q, busy_q, done_q, err_q} <= '0;
    end else if (abort || !stall) begin
      state <= nxt_state;
      layer_idx <= nxt_layer;
      step_idx <= nxt_step;
      if (cap) begin
        nl_q <= no_layers;
        sz_q <= layer_sz;
      end
      we_q <= nxt_state == LOAD;
      bsel_q <= nxt_state == LOAD && nxt_step != '0;
      ce_q <= nxt_state == MAC || nxt_state == ACT;
      af_q <= nxt_state == ACT;
      wr_q <= nxt_state == WRITE;
      shft_q <= nxt_shft;
      osel_q <= nxt_state != IDLE && nxt_layer != '0;
      busy_q <= nxt_state != IDLE;
      done_q <= nxt_state == DONE;
      err_q <= nxt_err;
    end
  seq_down_counter #(.W(CW)) u_phase (
    .clk(clk),
    .rst_n(rst_n),
    .load(ld),
    .en(~stall),
    .load_val(ld_val),
    .tc(tc)
  );
  assign weight_en = we_q & ~stall;
  assign bias_en = we_q & ~stall;
  assign compute_en = ce_q & ~stall;
  assign af_en = af_q & ~stall;
  assign out_shft_en = shft_q & ~stall;
  assign out_wr_en = wr_q & ~stall;
  assign out_sel = osel_q & ~stall;
  assign bias_sel = bsel_q & ~stall;
  assign done = done_q & ~stall;
  assign cfg_err = err_q & ~stall;
  assign busy = busy_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: scoreboard bench for nn_layer_sequencer (default instance plus a short-latency instance)
module tb_nn_layer_sequencer;
  localparam int ML = 8;
  localparam int NW = 6;
  localparam int LW = $clog2(ML + 1);
  localparam int SZW = (ML + 1) * NW;
  typedef struct {bit err; int cyc; int wr; int sh; int bs; int os; int ce; int we;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic start, abort, stall, start2;
  logic [LW-1:0] no_layers, nl2;
  logic [SZW-1:0] layer_sz, sz2;
  logic weight_en, bias_en, compute_en, af_en, out_shft_en, out_wr_en, out_sel, bias_sel, busy, done, cfg_err;
  logic [LW-1:0] layer_idx, layer_idx2;
  logic [NW-1:0] step_idx, step_idx2;
  logic weight_en2, bias_en2, compute_en2, af_en2, out_shft_en2, out_wr_en2, out_sel2, bias_sel2, busy2, done2, cfg_err2;
  nn_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .no_layers(no_layers), .layer_sz(layer_sz),
    .weight_en(weight_en), .bias_en(bias_en), .compute_en(compute_en), .af_en(af_en),
    .out_shft_en(out_shft_en), .out_wr_en(out_wr_en), .out_sel(out_sel), .bias_sel(bias_sel),
    .busy(busy), .done(done), .cfg_err(cfg_err), .layer_idx(layer_idx), .step_idx(step_idx)
  );
  nn_layer_sequencer #(.MAX_LAYERS(ML), .NW(NW), .MAC_LAT(2), .AF_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .stall(1'b0),
    .no_layers(nl2), .layer_sz(sz2),
    .weight_en(weight_en2), .bias_en(bias_en2), .compute_en(compute_en2), .af_en(af_en2),
    .out_shft_en(out_shft_en2), .out_wr_en(out_wr_en2), .out_sel(out_sel2), .bias_sel(bias_sel2),
    .busy(busy2), .done(done2), .cfg_err(cfg_err2), .layer_idx(layer_idx2), .step_idx(step_idx2)
  );
  wire [9:0] quiet1 = {weight_en, bias_en, compute_en, af_en, out_shft_en, out_wr_en, out_sel, bias_sel, done, cfg_err};
  wire [20:0] outs1 = {quiet1, busy, layer_idx, step_idx};
  wire [20:0] outs2 = {weight_en2, bias_en2, compute_en2, af_en2, out_shft_en2, out_wr_en2, out_sel2, bias_sel2,
                       done2, cfg_err2, busy2, layer_idx2, step_idx2};
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int failures = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int wr1, sh1, bs1, os1, ce1, we1, wr2, sh2, bs2, os2, ce2, we2;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [SZW-1:0] mk(input int a, input int b, input int c);
    logic [SZW-1:0] v;
    v = '0;
    v[NW-1:0] = NW'(a);
    v[2*NW-1:NW] = NW'(b);
    v[3*NW-1:2*NW] = NW'(c);
    return v;
  endfunction
  task automatic start_run(input int nl, input logic [SZW-1:0] sz, input bit push, input bit err, input int lat,
                           input int wr, input int sh, input int bs, input int os, input int ce, input int we,
                           output int c);
    no_layers = LW'(nl);
    layer_sz = sz;
    start = 1'b1;
    c = cyc;
    if (push) q1.push_back('{err, c + lat, wr, sh, bs, os, ce, we});
    tick(1);
    start = 1'b0;
  endtask
  // sizes {3,4,2}: 166 cycles to done, 2 writes, 3 shifts, 19 bias_sel, 87 out_sel, 134 compute, 27 weight
  task automatic nominal(input bit push, input int extra, output int c);
    start_run(2, mk(3, 4, 2), push, 1'b0, 166 + extra, 2, 3, 19, 87, 134, 27, c);
  endtask
  task automatic drain(input int bound);
    for (int i = 0; i < bound && (q1.size() + q2.size()) > 0; i++) tick(1);
    chk("drain_timeout", q1.size() + q2.size(), 0);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (!busy) begin
      wr1 = 0; sh1 = 0; bs1 = 0; os1 = 0; ce1 = 0; we1 = 0;
    end
    wr1 += int'(out_wr_en); sh1 += int'(out_shft_en); bs1 += int'(bias_sel);
    os1 += int'(out_sel); ce1 += int'(compute_en); we1 += int'(weight_en);
    if (stall) chk("stall_quiet", int'(quiet1), 0);
    if (done || cfg_err) begin
      chk("event_expected", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("event_kind", int'(cfg_err), int'(e1.err));
        chk("event_cycle", cyc, e1.cyc);
        if (e1.err) chk("err_busy", int'(busy), 0);
        else begin
          chk("wr_count", wr1, e1.wr);
          chk("shft_count", sh1, e1.sh);
          chk("bias_sel_count", bs1, e1.bs);
          chk("out_sel_count", os1, e1.os);
          chk("compute_count", ce1, e1.ce);
          chk("weight_count", we1, e1.we);
        end
      end
    end
  end
  always @(negedge clk) if (rst_n) begin
    if (!busy2) begin
      wr2 = 0; sh2 = 0; bs2 = 0; os2 = 0; ce2 = 0; we2 = 0;
    end
    wr2 += int'(out_wr_en2); sh2 += int'(out_shft_en2); bs2 += int'(bias_sel2);
    os2 += int'(out_sel2); ce2 += int'(compute_en2); we2 += int'(weight_en2);
    if (done2 || cfg_err2) begin
      chk("edge_event_expected", int'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        chk("edge_event_kind", int'(cfg_err2), int'(e2.err));
        chk("edge_event_cycle", cyc, e2.cyc);
        chk("edge_wr_count", wr2, e2.wr);
        chk("edge_shft_count", sh2, e2.sh);
        chk("edge_bias_sel_count", bs2, e2.bs);
        chk("edge_out_sel_count", os2, e2.os);
        chk("edge_compute_count", ce2, e2.ce);
        chk("edge_weight_count", we2, e2.we);
      end
    end
  end
  initial begin
    int c;
    start = 1'b0; abort = 1'b0; stall = 1'b0; start2 = 1'b0;
    no_layers = '0; layer_sz = '0; nl2 = '0; sz2 = '0;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", int'(outs1), 0);
    chk("reset_outputs_edge", int'(outs2), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    nominal(1'b1, 0, c);
    chk("start_busy", int'(busy), 1);
    chk("start_weight_en", int'(weight_en), 1);
    chk("start_layer_idx", int'(layer_idx), 0);
    drain(400);
    start_run(0, mk(3, 4, 2), 1'b1, 1'b1, 1, 0, 0, 0, 0, 0, 0, c);
    tick(3);
    chk("err_idle_busy", int'(busy), 0);
    start_run(2, mk(3, 0, 2), 1'b1, 1'b1, 1, 0, 0, 0, 0, 0, 0, c);
    tick(3);
    chk("err_idle_busy2", int'(busy), 0);
    start_run(9, mk(3, 4, 2), 1'b1, 1'b1, 1, 0, 0, 0, 0, 0, 0, c);
    tick(3);
    drain(10);
    nominal(1'b1, 7, c);
    tick(49);
    stall = 1'b1;
    tick(7);
    stall = 1'b0;
    drain(400);
    nominal(1'b0, 0, c);
    tick(84);
    chk("pre_abort_compute", int'(compute_en), 1);
    chk("pre_abort_layer", int'(layer_idx), 1);
    abort = 1'b1;
    start = 1'b1;
    tick(1);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_outputs", int'(outs1), 0);
    tick(200);
    nominal(1'b1, 0, c);
    drain(400);
    nominal(1'b1, 0, c);
    tick(30);
    chk("busy_before_reset", int'(busy), 1);
    #2 rst_n = 1'b0;
    q1.delete();
    #1 chk("reset_mid_outputs", int'(outs1), 0);
    tick(2);
    rst_n = 1'b1;
    tick(200);
    chk("idle_after_reset", int'(busy), 0);
    nominal(1'b1, 0, c);
    drain(400);
    nl2 = LW'(1);
    sz2 = mk(1, 1, 0);
    start2 = 1'b1;
    c = cyc;
    q2.push_back('{1'b0, c + 10, 1, 0, 0, 1, 5, 2});
    tick(1);
    start2 = 1'b0;
    tick(2);
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    chk("edge_busy_mid", int'(busy2), 1);
    drain(50);
    tick(20);
    chk("edge_idle_end", int'(busy2), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nn_layer_sequencer.md
NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_LAYERS, default 8, the maximum number of compute layers.
REQ-002 The block SHALL have parameter NW, default 6, the bit width of a layer-size field.
REQ-003 The block SHALL have parameter MAC_LAT, default 10, the CORDIC multiply-accumulate cycles per fan-in step.
REQ-004 The block SHALL have parameter AF_LAT, default 32, the CORDIC activation cycles per layer.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit, a request to begin a run.
REQ-008 The block SHALL have port abort, input, 1 bit, a request to return to IDLE.
REQ-009 The block SHALL have port stall, input, 1 bit, which freezes the sequence.
REQ-010 The block SHALL have port no_layers, input, LW=$clog2(MAX_LAYERS+1) bits, the compute-layer count.
REQ-011 The block SHALL have port layer_sz, input, (MAX_LAYERS+1)*NW bits; field k at bits [k*NW +: NW] is the size of layer k, and field 0 is the input count.
REQ-012 The block SHALL have outputs weight_en, bias_en, compute_en, af_en, out_shft_en, out_wr_en, out_sel and bias_sel, each 1 bit, all datapath strobes.
REQ-013 The block SHALL have outputs busy (1 bit), done (1-cycle pulse) and cfg_err (1-cycle pulse).
REQ-014 The block SHALL have output layer_idx, LW bits, and output step_idx, NW bits, the current layer and fan-in index.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, MAC, ACT, WRITE, NEXT and DONE.
REQ-016 In IDLE with start=1, the block SHALL capture no_layers and layer_sz into internal registers; later input changes SHALL NOT affect the run.
REQ-017 cfg_err SHALL pulse and the FSM SHALL stay in IDLE if no_layers==0, no_layers>MAX_LAYERS, or any field k<=no_layers is 0.
REQ-018 On a legal start, the FSM SHALL go to LOAD with layer_idx=0 and step_idx=0, and busy SHALL go to 1 on the next cycle.
REQ-019 For layer n, fan-in FI=sz[n] and fan-out FO=sz[n+1].
REQ-020 In LOAD, weight_en and bias_en SHALL be 1 for exactly FO+1 cycles, then the FSM SHALL go to MAC.
REQ-021 In LOAD, bias_sel SHALL be 0 when step_idx==0 and 1 otherwise.
REQ-022 In MAC, compute_en SHALL be 1 for exactly MAC_LAT cycles.
REQ-023 At the end of MAC, if step_idx<FI-1, the block SHALL increment step_idx, return to LOAD, and pulse out_shft_en for 1 cycle when layer_idx!=0.
REQ-024 At the end of MAC, if step_idx==FI-1, the FSM SHALL go to ACT.
REQ-025 In ACT, compute_en and af_en SHALL be 1 for exactly AF_LAT cycles, then the FSM SHALL go to WRITE.
REQ-026 WRITE SHALL last 1 cycle with out_wr_en=1.
REQ-027 NEXT SHALL last 1 cycle and increment layer_idx; if layer_idx==no_layers, the FSM SHALL go to DONE, else to LOAD with step_idx=0.
REQ-028 out_sel SHALL be 0 while layer_idx==0 and 1 otherwise.
REQ-029 DONE SHALL pulse done for 1 cycle and then return to IDLE with busy=0; a new run is accepted from that IDLE.
REQ-030 While stall=1, all state, counters and index registers SHALL hold, and all strobes except busy SHALL be forced to 0; on release the sequence SHALL resume with no cycle lost or repeated.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 abort SHALL have priority over stall and start, and SHALL return the FSM to IDLE next cycle with all strobes 0 and no done pulse.
REQ-033 A FI==1 layer SHALL take LOAD, MAC, ACT, WRITE, NEXT with no out_shft_en.
REQ-034 Total cycles for layer n SHALL be FI*(FO+1+MAC_LAT)+AF_LAT+2.
REQ-035 Cycle counters SHALL be wide enough for max(2^NW, MAC_LAT, AF_LAT) without wrap.

Reset
REQ-036 With rst_n=0, asynchronously: state=IDLE and every output=0 (incl. layer_idx, step_idx, busy).
REQ-037 Reset mid-run SHALL discard the run; after release, the block SHALL wait for a new start.

Structure
REQ-038 A shared package (nn_ctrl_pkg) SHALL hold the state enum, the default latency constants and a layer-size field-extract function.
REQ-039 One sub-module, seq_down_counter (loadable, stall-gated, terminal-count flag), SHALL be instantiated for the phase timer.

Verification
REQ-040 Reset: rst_n low during a run, layer_sz={3,4,2}, no_layers=2 -> all outputs 0 immediately; no done until a new start.
REQ-041 Nominal: layer_sz={3,4,2}, no_layers=2 -> layer0 takes 3*(5+10)+34=79 cycles and layer1 4*(3+10)+34=86; done at cycle 166 after start; out_wr_en pulses twice; out_shft_en 3 times.
REQ-042 Illegal config: no_layers=0, and separately sz[1]=0 -> cfg_err 1 pulse, busy stays 0.
REQ-043 Stall: stall high 7 cycles inside ACT of layer0 -> done exactly 7 cycles later than nominal; strobes 0 during the stall.
REQ-044 Abort: abort in MAC of layer1 with start held -> IDLE next cycle, no done; a subsequent start completes normally.
REQ-045 Edge: FI=1, FO=1, no_layers=1, MAC_LAT=2, AF_LAT=3 -> done 2+2+3+2=9 cycles after LOAD entry; start mid-run ignored.
